// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        WAIT_R = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

endpackage

// File: rtl/ifu_fetch_stage_if.sv
// AXI4-Lite-style read channel between the fetch stage (master) and instruction memory (slave).
interface ifu_fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ifu_fetch_stage.sv
// Instruction fetch stage: one read per instruction, sequential PC+4 prediction, decode redirects.
// Optional performance counters with getter functions when IFU_PERF_COUNTERS_EN is defined.
module ifu_fetch_stage
    import ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h3000_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    ifu_fetch_stage_if.master    bus,
    output logic [31:0]          inst,
    output logic [ADDR_W-1:0]    ifu_to_idu_pc,
    output logic                 ifu_valid,
    input  logic                 ifu_ready,
    output logic [63:0]          num,
    input  logic                 control_hazard,
    input  logic [ADDR_W-1:0]    branch_target_pc,
    output logic                 fetch_fault
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [63:0]       num_reg, num_next;
    logic              flush_reg, flush_next;
    logic              fault_reg, fault_next;
    logic [31:0]       inst_reg, inst_next;
    logic [ADDR_W-1:0] out_pc_reg, out_pc_next;
    logic              beat_deliver;
    logic              beat_discard;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg  <= REQ;
            pc_reg     <= RESET_PC;
            num_reg    <= '0;
            flush_reg  <= 1'b0;
            fault_reg  <= 1'b0;
            inst_reg   <= '0;
            out_pc_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            num_reg    <= num_next;
            flush_reg  <= flush_next;
            fault_reg  <= fault_next;
            inst_reg   <= inst_next;
            out_pc_reg <= out_pc_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        num_next     = num_reg;
        flush_next   = flush_reg;
        fault_next   = fault_reg;
        inst_next    = inst_reg;
        out_pc_next  = out_pc_reg;
        beat_deliver = 1'b0;
        beat_discard = 1'b0;
        case (state_reg)
            REQ: begin
                if (bus.arready) begin
                    state_next = WAIT_R;
                    // Request already accepted: its beat must be dropped when it returns.
                    if (control_hazard) begin
                        flush_next = 1'b1;
                        pc_next    = branch_target_pc;
                    end
                end else if (control_hazard) begin
                    pc_next = branch_target_pc;
                end
            end
            WAIT_R: begin
                if (control_hazard) begin
                    pc_next = branch_target_pc;
                    if (bus.rvalid) begin
                        beat_discard = 1'b1;
                        flush_next   = 1'b0;
                        state_next   = REQ;
                    end else begin
                        flush_next = 1'b1;
                    end
                end else if (bus.rvalid) begin
                    if (flush_reg) begin
                        beat_discard = 1'b1;
                        flush_next   = 1'b0;
                        state_next   = REQ;
                    end else begin
                        beat_deliver = 1'b1;
                        out_pc_next  = pc_reg;
                        num_next     = num_reg + 64'd1;
                        state_next   = HOLD;
                        if (bus.rresp != RESP_OKAY) begin
                            inst_next  = NOP_INST;
                            fault_next = 1'b1;
                        end else begin
                            inst_next = bus.rdata;
                        end
                    end
                end
            end
            HOLD: begin
                if (control_hazard) begin
                    pc_next    = branch_target_pc;
                    state_next = REQ;
                end else if (ifu_ready) begin
                    pc_next    = pc_reg + ADDR_W'(4);
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // Gating with reset keeps the handshakes quiet during the reset cycle itself.
    assign bus.arvalid   = reset && (state_reg == REQ);
    assign bus.araddr    = pc_reg;
    assign bus.rready    = reset && (state_reg == WAIT_R);
    assign ifu_valid     = reset && (state_reg == HOLD);
    assign inst          = inst_reg;
    assign ifu_to_idu_pc = out_pc_reg;
    assign num           = num_reg;
    assign fetch_fault   = fault_reg;

`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] fetch_count_reg;
    logic [31:0] squash_count_reg;
    logic [31:0] stall_cycles_reg;
    logic        hold_squash;

    assign hold_squash = (state_reg == HOLD) && control_hazard;

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_count_reg  <= '0;
            squash_count_reg <= '0;
            stall_cycles_reg <= '0;
        end else begin
            if (beat_deliver)
                fetch_count_reg <= fetch_count_reg + 32'd1;
            if (beat_discard || hold_squash)
                squash_count_reg <= squash_count_reg + 32'd1;
            if (state_reg != HOLD)
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    function automatic int unsigned get_fetch_count();
        return fetch_count_reg;
    endfunction

    function automatic int unsigned get_squash_count();
        return squash_count_reg;
    endfunction

    function automatic int unsigned get_stall_cycles();
        return stall_cycles_reg;
    endfunction
`endif

endmodule
